// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO: start bit, LSB-first data, optional parity, stop bit(s).
// One serial bit per uart_clk_rx cycle; line, busy and done are registered from next-state values.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                  uart_clk_rx,
  input  logic                                  RST_n,
  input  logic [DATA_BITS-1:0]                  tx_data,
  input  logic                                  tx_valid,
  output logic                                  tx_ready,
  output logic                                  uart_tx_data,
  output logic                                  tx_busy,
  output logic                                  tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_state_nx;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit;
  logic                 r_stop, r_par, r_line, r_busy, r_done;
  logic                 w_push, w_pop, w_empty, w_last_bit, w_last_stop;
  logic                 w_line_nx, w_busy_nx, w_done_nx;
  logic [DATA_BITS-1:0] w_head;

  assign tx_ready     = (r_count != CW'(FIFO_DEPTH));
  assign w_push       = tx_valid && tx_ready;
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_last_bit   = (r_bit == BW'(DATA_BITS - 1));
  assign w_last_stop  = (r_stop == 1'(STOP_BITS - 1));
  assign uart_tx_data = r_line;
  assign tx_busy      = r_busy;
  assign tx_done      = r_done;
  assign fifo_count   = r_count;

  // Outputs are computed for the state being entered, so the pop edge already drives the start bit.
  always_comb begin
    w_state_nx = r_state;
    w_line_nx  = 1'b1;
    w_busy_nx  = 1'b1;
    w_done_nx  = 1'b0;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nx = 1'b0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = S_START;
          w_line_nx  = 1'b0;
          w_busy_nx  = 1'b1;
        end
      end
      S_START: begin
        w_state_nx = S_DATA;
        w_line_nx  = r_shift[0];
      end
      S_DATA: begin
        if (!w_last_bit) begin
          w_line_nx = r_shift[0];
        end else if (PARITY != 0) begin
          w_state_nx = S_PARITY;
          w_line_nx  = r_par;
        end else begin
          w_state_nx = S_STOP;
          w_done_nx  = (STOP_BITS == 1);
        end
      end
      S_PARITY: begin
        w_state_nx = S_STOP;
        w_done_nx  = (STOP_BITS == 1);
      end
      S_STOP: begin
        if (!w_last_stop) begin
          w_done_nx = 1'b1;
        end else if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = S_START;
          w_line_nx  = 1'b0;
        end else begin
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge uart_clk_rx) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge uart_clk_rx) begin
    if (!RST_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_par    <= 1'b0;
      r_line   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_line  <= w_line_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
        r_bit   <= '0;
      end else if (r_state == S_START || (r_state == S_DATA && !w_last_bit)) begin
        r_shift <= r_shift >> 1;
      end
      if (r_state == S_DATA && !w_last_bit) r_bit <= r_bit + 1'b1;
      if (r_state == S_STOP) r_stop <= r_stop + 1'b1;
      else                   r_stop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serial-line monitor decodes frames and checks them against a queue of
// words pushed by the stimulus; directed timing checks cover latency, back-pressure, parity and reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       RST_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, line, busy, done;
  logic [2:0] count;

  logic [7:0] p_data;
  logic       p_valid;
  logic       e_ready, e_line, e_busy, e_done;
  logic       o_ready, o_line, o_busy, o_done;
  logic [2:0] e_count, o_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo u_dut (
    .uart_clk_rx(clk), .RST_n(RST_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx_data(line), .tx_busy(busy), .tx_done(done), .fifo_count(count)
  );

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4)) u_even (
    .uart_clk_rx(clk), .RST_n(RST_n), .tx_data(p_data), .tx_valid(p_valid),
    .tx_ready(e_ready), .uart_tx_data(e_line), .tx_busy(e_busy), .tx_done(e_done), .fifo_count(e_count)
  );

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(4)) u_odd (
    .uart_clk_rx(clk), .RST_n(RST_n), .tx_data(p_data), .tx_valid(p_valid),
    .tx_ready(o_ready), .uart_tx_data(o_line), .tx_busy(o_busy), .tx_done(o_done), .fifo_count(o_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds tx_valid until the word is accepted; waited = edges until the accepting edge.
  task automatic push_hold(input logic [7:0] d, output int waited);
    logic acc;
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    forever begin
      acc = tx_ready;
      @(posedge clk); #1;
      waited++;
      if (acc) begin
        exp_q.push_back(d);
        break;
      end
      if (waited >= 100) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && count == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wait_idle", ok, 1);
  endtask

  // Serial monitor: decodes frames from the line and scores them against exp_q.
  int         m_ph = 0;
  int         m_nb = 0;
  logic [7:0] m_w;
  initial begin
    forever begin
      @(negedge clk);
      if (RST_n !== 1'b1) begin
        m_ph = 0;
        continue;
      end
      case (m_ph)
        0: if (line === 1'b0) begin
             m_ph = 1;
             m_nb = 0;
           end
        1: begin
             m_w[m_nb] = line;
             m_nb++;
             if (m_nb == 8) m_ph = 2;
           end
        default: begin
             chk("stop_bit", line, 1);
             chk("done_on_stop", done, 1);
             chk("busy_on_stop", busy, 1);
             if (exp_q.size() == 0) chk("unexpected_frame", m_w, 32'hFFFF_FFFF);
             else                   chk("rx_word", m_w, exp_q.pop_front());
             m_ph = 0;
           end
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int w;
    int lows;
    logic [10:0] e_a5;
    logic [11:0] e_even, e_odd;
    e_a5   = 11'b11101001010;
    e_even = 12'b111000001110;
    e_odd  = 12'b110000001110;

    RST_n = 1'b0; tx_data = '0; tx_valid = 1'b0; p_data = '0; p_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", tx_ready, 1);
    RST_n = 1'b1;
    @(posedge clk); #1;

    // 1: single frame 0xA5, start bit from the edge after the write
    wait_idle();
    push_hold(8'hA5, w);
    chk("t1_count_after_push", count, 1);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_line_%0d", i), line, e_a5[i]);
      chk($sformatf("t1_done_%0d", i), done, (i == 9) ? 1 : 0);
    end
    chk("t1_idle_busy", busy, 0);

    // 2: back-to-back frames without idle gap
    wait_idle();
    push_hold(8'h01, w);
    chk("t2_count_a", count, 1);
    push_hold(8'h02, w);
    chk("t2_count_b", count, 1);
    push_hold(8'h03, w);
    chk("t2_count_c", count, 2);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_done1", done, 1);
    @(posedge clk); #1;
    chk("t2_start2_line", line, 0);
    chk("t2_start2_busy", busy, 1);
    chk("t2_count_d", count, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_start3_line", line, 0);
    chk("t2_count_e", count, 0);
    repeat (9) @(posedge clk);
    #1;
    chk("t2_done3", done, 1);
    @(posedge clk); #1;
    chk("t2_idle_line", line, 1);
    chk("t2_idle_busy", busy, 0);

    // 3: fill the FIFO while a frame is in flight; 6th word waits for the pop
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      push_hold(8'h10 + 8'(i), w);
      chk($sformatf("t3_wait_%0d", i), w, 1);
    end
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", tx_ready, 0);
    push_hold(8'h15, w);
    chk("t3_blocked_edges", w, 8);
    chk("t3_count_after", count, 4);

    // 4: parity variants, 0x07 has three ones
    wait_idle();
    p_data = 8'h07; p_valid = 1'b1;
    @(posedge clk); #1;
    p_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t4_even_%0d", i), e_line, e_even[i]);
      chk($sformatf("t4_odd_%0d", i), o_line, e_odd[i]);
    end
    chk("t4_even_idle", e_busy, 0);
    chk("t4_odd_idle", o_busy, 0);

    // 5: reset mid-frame with two words queued
    wait_idle();
    push_hold(8'h5A, w);
    push_hold(8'h3C, w);
    push_hold(8'hC3, w);
    chk("t5_queued", count, 2);
    repeat (2) @(posedge clk);
    #1;
    RST_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    chk("t5_line", line, 1);
    chk("t5_busy", busy, 0);
    chk("t5_count", count, 0);
    chk("t5_done", done, 0);
    RST_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (line !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("t5_no_frames", lows, 0);

    // 6: random words with random valid gaps, checked by the monitor
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push_hold(8'($urandom_range(0, 255)), w);
    end
    begin
      logic ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(posedge clk); #1;
        if (exp_q.size() == 0 && !busy) begin
          ok = 1'b1;
          break;
        end
      end
      chk("t6_drained", ok, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
